// File: rtl/riscv_div_unit.sv
// riscv_div_unit
// Iterative RISC-V M-extension divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle, 32 cycles per
// divide plus a sign-fix cycle. Divide-by-zero and signed overflow skip
// the iteration and produce their architectural results directly.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | 32 shift-subtract iterations on operand magnitudes
// FIX   | apply result signs, select quotient/remainder into result
// DONE  | result valid, held until the consumer takes it
//
// Ports
//   clk        : system clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present
//   in_ready   : unit can accept a request (IDLE only)
//   op         : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend   : rs1 operand
//   divisor    : rs2 operand
//   out_valid  : result present (DONE only)
//   out_ready  : consumer accepts result
//   result     : quotient or remainder selected by op
module riscv_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic [1:0]  r_op;
    logic [31:0] r_divisor;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [4:0]  r_count;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_ovf;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // op[0] clear means a signed operation (DIV, REM).
    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & dividend[31];
    assign w_b_neg    = w_signed & divisor[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - dividend) : dividend;
    assign w_b_mag    = w_b_neg ? (32'd0 - divisor) : divisor;
    assign w_div_zero = (divisor == 32'd0);
    assign w_ovf      = w_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    // 33-bit partial remainder: shift in the next dividend bit, trial subtract.
    // Bit 32 of the difference is the borrow; the stored remainder is always
    // below the divisor, so it fits back into 32 bits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_sub   = w_shift - {1'b0, r_divisor};

    assign w_quo_fix = r_q_neg ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_op        <= 2'd0;
            r_divisor   <= 32'd0;
            r_quo       <= 32'd0;
            r_rem       <= 32'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_count     <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_div_zero) begin
                            r_result    <= op[1] ? dividend : 32'hFFFF_FFFF;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_ovf) begin
                            r_result    <= op[1] ? 32'd0 : 32'h8000_0000;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_op      <= op;
                            r_quo     <= w_a_mag;
                            r_rem     <= 32'd0;
                            r_divisor <= w_b_mag;
                            r_q_neg   <= w_a_neg ^ w_b_neg;
                            r_r_neg   <= w_a_neg;
                            r_count   <= 5'd31;
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    // r_quo doubles as the dividend shift register: its MSB
                    // feeds the remainder while quotient bits enter at the LSB.
                    if (w_sub[32]) begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end else begin
                        r_rem <= w_sub[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end
                    if (r_count == 5'd0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                FIX: begin
                    r_result    <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed testbench for riscv_div_unit: each task drives one scenario and
// compares outputs against hand-computed RISC-V M results and latencies.
module tb_riscv_div_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    riscv_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE, scramble the inputs right after the
    // accept edge, and return the cycle count to out_valid (-1 on timeout)
    // plus the result seen there. Leaves the unit in DONE with out_ready 0.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
        op       = o;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = ~o;
        dividend = ~a;
        divisor  = b + 32'h1234;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = OP_DIVU;
        dividend  = 32'd100;
        divisor   = 32'd7;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        // in_valid was high under reset; nothing may have been accepted.
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_priority_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_signed();
        logic [1:0]  v_op  [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] v_a   [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd7, 32'd7};
        logic [31:0] v_b   [4] = '{32'd3, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] v_exp [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], lat, res);
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL signed_latency[%0d] got %0d want 34", i, lat); end
            checks++;
            if (res !== v_exp[i]) begin errors++; $display("FAIL signed_result[%0d] got %h want %h", i, res, v_exp[i]); end
            drain();
        end
    endtask

    task automatic test_unsigned();
        logic [1:0]  v_op  [3] = '{OP_DIVU, OP_REMU, OP_DIVU};
        logic [31:0] v_a   [3] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'h8000_0000};
        logic [31:0] v_b   [3] = '{32'd3, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] v_exp [3] = '{32'h5555_554E, 32'd2, 32'd0};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], lat, res);
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL unsigned_latency[%0d] got %0d want 34", i, lat); end
            checks++;
            if (res !== v_exp[i]) begin errors++; $display("FAIL unsigned_result[%0d] got %h want %h", i, res, v_exp[i]); end
            drain();
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  v_op  [4] = '{OP_DIV, OP_REMU, OP_DIVU, OP_REM};
        logic [31:0] v_a   [4] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] v_exp [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            do_op(v_op[i], v_a[i], 32'd0, lat, res);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL divzero_latency[%0d] got %0d want 1", i, lat); end
            checks++;
            if (res !== v_exp[i]) begin errors++; $display("FAIL divzero_result[%0d] got %h want %h", i, res, v_exp[i]); end
            drain();
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  v_op  [2] = '{OP_DIV, OP_REM};
        logic [31:0] v_exp [2] = '{32'h8000_0000, 32'd0};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 2; i++) begin
            do_op(v_op[i], 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL overflow_latency[%0d] got %0d want 1", i, lat); end
            checks++;
            if (res !== v_exp[i]) begin errors++; $display("FAIL overflow_result[%0d] got %h want %h", i, res, v_exp[i]); end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        int bad_valid = 0;
        int bad_result = 0;
        int bad_ready = 0;
        do_op(OP_DIVU, 32'd1000, 32'd9, lat, res);
        checks++;
        if (res !== 32'd111) begin errors++; $display("FAIL bp_result got %h want 0000006f", res); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1) bad_valid++;
            if (result !== 32'd111) bad_result++;
            if (in_ready !== 1'b0) bad_ready++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad_valid != 0) begin errors++; $display("FAIL bp_hold_valid dropped %0d cycles want 0", bad_valid); end
        checks++;
        if (bad_result != 0) begin errors++; $display("FAIL bp_hold_result changed %0d cycles want 0", bad_result); end
        checks++;
        if (bad_ready != 0) begin errors++; $display("FAIL bp_in_ready high %0d cycles want 0", bad_ready); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++;
        if (result !== 32'd111) begin errors++; $display("FAIL bp_idle_result got %h want 0000006f", result); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [31:0] res;
        int stale = 0;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL calc_in_ready got %b want 0", in_ready); end
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midcalc_reset got valid %b ready %b want 0 1", out_valid, in_ready);
        end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL midcalc_reset_result got %h want 00000000", result); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL midcalc_stale_valid seen %0d cycles want 0", stale); end
        do_op(OP_DIVU, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL after_reset_latency got %0d want 34", lat); end
        checks++;
        if (res !== 32'h0000_000E) begin errors++; $display("FAIL after_reset_result got %h want 0000000e", res); end
        drain();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
RISCV_DIV_UNIT -- requirements
Module: riscv_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend, input, 32 bits: rs1 operand.
REQ-007 SHALL have port divisor, input, 32 bits: rs2 operand.
REQ-008 SHALL have port out_valid, output, 1 bit: result present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have port result, output, 32 bits: quotient or remainder per op.

Function
REQ-011 SHALL have FSM states IDLE, CALC, FIX, DONE.
REQ-012 SHALL assert in_ready only in IDLE; a request is accepted on a cycle with in_valid && in_ready.
REQ-013 SHALL latch op, dividend and divisor at acceptance; later input changes SHALL NOT affect the result.
REQ-014 For signed ops (DIV, REM), SHALL convert each operand to magnitude: two's-complement negate when bit 31 is set, else pass through; SHALL record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
REQ-015 For unsigned ops, SHALL use operands unchanged and clear q_neg and r_neg.
REQ-016 Normal path: IDLE -> CALC on acceptance; CALC SHALL run exactly 32 restoring shift-subtract iterations, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
REQ-017 CALC -> FIX after iteration 32; FIX SHALL negate the quotient when q_neg is set and the remainder when r_neg is set (two's complement, 32-bit wrap), select quotient for DIV/DIVU or remainder for REM/REMU, and register it to result.
REQ-018 FIX -> DONE; out_valid SHALL be 1 exactly in DONE, i.e. the 34th cycle after the acceptance cycle.
REQ-019 Divide by zero (divisor == 0) SHALL bypass CALC: IDLE -> DONE, with result 0xFFFFFFFF for DIV/DIVU and result = dividend for REM/REMU; out_valid on the 1st cycle after acceptance.
REQ-020 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) SHALL bypass CALC: IDLE -> DONE, with result 0x80000000 for DIV and 0x00000000 for REM; out_valid on the 1st cycle after acceptance.
REQ-021 Divide by zero SHALL take precedence over the overflow check.
REQ-022 In DONE, result and out_valid SHALL be held stable until out_valid && out_ready; DONE -> IDLE on that cycle.
REQ-023 in_ready SHALL be 0 on the cycle out_valid && out_ready occurs; a new request SHALL be accepted no earlier than the following cycle (no back-to-back overlap).
REQ-024 result SHALL be held unchanged in IDLE, CALC and FIX; it changes only on entry to DONE.
REQ-025 The unit SHALL raise no exceptions; all cases yield a defined value per RISC-V M.

Reset
REQ-026 rst SHALL force state IDLE, in_ready 1, out_valid 0, result 0x00000000, internal quotient, remainder and sign flags 0.
REQ-027 rst asserted in any state, including mid-CALC and DONE, SHALL abort the operation with no result emitted; rst has priority over in_valid on the same cycle.

Verification
REQ-028 DIV, dividend 0xFFFFFFEC (-20), divisor 3 -> out_valid 34 cycles after accept, result 0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2).
REQ-029 DIVU, dividend 0xFFFFFFEC, divisor 3 -> result 0x5555554E; REMU same operands -> result 0x00000002.
REQ-030 DIV and REMU with divisor 0, dividend 0x12345678 -> out_valid 1 cycle after accept; result 0xFFFFFFFF for DIV and 0x12345678 for REMU.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 after 1 cycle; REM same operands -> result 0x00000000.
REQ-032 Hold out_ready 0 for 10 cycles in DONE -> result and out_valid stable throughout, in_ready 0; then out_ready 1 -> out_valid drops and in_ready rises the next cycle.
REQ-033 Assert rst at CALC iteration 16, then issue a new DIVU 100 / 7 -> no stale out_valid; result 0x0000000E 34 cycles after the new accept.
